if_branch_redirect: RTL
=======================

// Module: if_branch_redirect
// PURPOSE
//   Fetch-side consumer of the ID-stage branch decision. Owns the fetch PC and
//   drives the instruction-memory request handshake (req/addr_ok). Applies taken
//   branches/jumps after the MIPS delay slot. Tags wrong-path fetches for discard.
//   Applies exception redirects with top priority.
// PARAMETERS
//   RESET_PC  32'hBFC00000  fetch address after reset
//   CNT_W     32            width of statistics counters (IF_REDIRECT_STATS_EN only)
// PORTS
//   clk             in   1   single clock; all state updates on rising edge
//   resetn          in   1   synchronous, active-low reset
//   stall_i         in   1   pipeline stall; ID contents held, fetch request suppressed
//   inst_req_o      out  1   fetch request valid
//   inst_addr_o     out  32  fetch address (= fetch_pc)
//   inst_addr_ok_i  in   1   memory accepted request this cycle
//   inst_kill_o     out  1   accepted request this cycle is wrong-path; drop its data
//   br_valid_i      in   1   ID holds a branch/jump instruction this cycle
//   br_taken_i      in   1   branch resolution from the ID branch evaluator
//   br_target_i     in   32  resolved target
//   id_pc_i         in   32  PC of the instruction in ID
//   excp_valid_i    in   1   exception/ERET redirect, one-cycle pulse
//   excp_target_i   in   32  exception redirect address
//   redirect_cnt_o  out CNT_W taken redirects applied (IF_REDIRECT_STATS_EN only)
//   kill_cnt_o      out CNT_W wrong-path fetches killed (IF_REDIRECT_STATS_EN only)
// BEHAVIOUR
//   Reset:
//     fetch_pc=RESET_PC; state=SEQ; pend_tgt=0; acc_any=0; last_acc=0;
//     inst_req_o=0; inst_kill_o=0; counters=0.
//   inst_req_o = resetn_q & ~stall_i & ~excp_valid_i.
//     resetn_q is resetn registered, so req first rises one cycle after release.
//   accept = inst_req_o & inst_addr_ok_i.
//     On accept: last_acc<=fetch_pc, acc_any<=1.
//   fetch_pc may change only on an accept cycle or a cycle with inst_req_o=0.
//     Otherwise the address is held stable.
//   br_evt = br_valid_i & br_taken_i & ~stall_i & state==SEQ.
//     Ignored in other states.
//     Not-taken branches need no action.
//   ds_addr = id_pc_i+4. ds_done = acc_any & (last_acc==ds_addr).
//   States:
//     SEQ: no redirect pending.
//       On accept: fetch_pc+=4.
//       br_evt with ~ds_done:
//         if accept of ds_addr this cycle: fetch_pc<=br_target_i, stay SEQ.
//         else: pend_tgt<=br_target_i, go to WAIT_DS.
//       br_evt with ds_done:
//         if accept this cycle: inst_kill_o=1, fetch_pc<=br_target_i.
//         elif inst_req_o=0: fetch_pc<=br_target_i.
//         else: pend_tgt<=br_target_i, go to REDIR.
//     WAIT_DS: delay slot not yet accepted.
//       On accept (the DS): fetch_pc<=pend_tgt, go to SEQ.
//     REDIR: wrong-path address is being held.
//       On accept: inst_kill_o=1, fetch_pc<=pend_tgt, go to SEQ.
//       If inst_req_o=0: fetch_pc<=pend_tgt, go to SEQ, no kill.
//   Exception: excp_valid_i overrides everything, including stall and pending state.
//     fetch_pc<=excp_target_i; state<=SEQ; any br_evt that cycle is dropped.
//     inst_req_o=0 that cycle, so no kill is generated.
//   inst_kill_o is combinational and asserted only together with accept.
//   Redirect latency: if ds_done and the memory accepts every cycle,
//     exactly one wrong-path fetch (id_pc+8) is killed.
//   Address arithmetic is mod 2^32; 32'hFFFFFFFC+4 wraps to 0.
//     Target bits [1:0] pass through unchecked (alignment faults raised downstream).
//   resetn low mid-redirect: pending target is discarded; fetch restarts at RESET_PC.
// CONFIGURATION
//   IF_REDIRECT_STATS_EN defined:
//     redirect_cnt_o increments on each cycle fetch_pc is loaded from a branch target.
//     kill_cnt_o increments on each inst_kill_o.
//     Both saturate at all-ones and clear on reset.
//   IF_REDIRECT_STATS_EN undefined: both ports and counters are absent.
//     All other behaviour is identical.
// TESTING
//   Reset release, addr_ok=1 constant -> req rises 1 cycle later;
//     addresses BFC00000, BFC00004, BFC00008...
//   Taken branch id_pc=BFC00000, target=BFC00100, DS BFC00004 already accepted:
//     BFC00008 accepted with kill=1, next address BFC00100.
//   Branch at id_pc=100, target=200, addr_ok=0 while 104 is requested:
//     state WAIT_DS, addr held at 104; after addr_ok: 104 with kill=0, then 200.
//   excp_valid_i=1 (target BFC00380) in the same cycle as a br_evt in REDIR:
//     req=0 that cycle; next address BFC00380; no kill; state SEQ.
//   stall_i=1 while in REDIR: req=0, fetch_pc<=pend_tgt, no kill;
//     after stall release, target is fetched first.
//   With IF_REDIRECT_STATS_EN: after scenarios 2-3, redirect_cnt_o=2 and kill_cnt_o=1.

Source files
------------

// File: rtl/if_branch_redirect_if.sv
// Instruction-memory request handshake between the fetch PC owner and memory.
// The fetch side is the master; the memory answers with addr_ok.
interface if_branch_redirect_if;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_kill_o;

    modport master (
        output inst_req_o,
        output inst_addr_o,
        output inst_kill_o,
        input  inst_addr_ok_i
    );

    modport slave (
        input  inst_req_o,
        input  inst_addr_o,
        input  inst_kill_o,
        output inst_addr_ok_i
    );
endinterface

// File: rtl/if_branch_redirect.sv
// Fetch PC owner: applies taken branches after the delay slot, kills wrong-path fetches.
// Optional statistics counters are enabled with IF_REDIRECT_STATS_EN.
module if_branch_redirect #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
`ifdef IF_REDIRECT_STATS_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                stall_i,
    if_branch_redirect_if.master imem,
    input  logic                br_valid_i,
    input  logic                br_taken_i,
    input  logic [31:0]         br_target_i,
    input  logic [31:0]         id_pc_i,
    input  logic                excp_valid_i,
    input  logic [31:0]         excp_target_i
`ifdef IF_REDIRECT_STATS_EN
    ,
    output logic [CNT_W-1:0]    redirect_cnt_o,
    output logic [CNT_W-1:0]    kill_cnt_o
`endif
);
    typedef enum logic [1:0] {SEQ, WAIT_DS, REDIR} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] pend_tgt;
    logic [31:0] last_acc;
    logic        acc_any;
    logic        resetn_q;

    logic        req;
    logic        accept;
    logic        br_evt;
    logic [31:0] ds_addr;
    logic        ds_done;
    logic        ds_now;
    logic [31:0] pc_inc;
    logic        kill;

    assign req     = resetn_q & ~stall_i & ~excp_valid_i;
    assign accept  = req & imem.inst_addr_ok_i;
    assign br_evt  = br_valid_i & br_taken_i & ~stall_i & (state == SEQ);
    assign ds_addr = id_pc_i + 32'd4;
    assign ds_done = acc_any & (last_acc == ds_addr);
    assign ds_now  = accept & (fetch_pc == ds_addr);
    assign pc_inc  = fetch_pc + 32'd4;

    // A kill only ever marks a request the memory is accepting right now.
    assign kill = accept & ((state == REDIR) | (br_evt & ds_done));

    assign imem.inst_req_o  = req;
    assign imem.inst_addr_o = fetch_pc;
    assign imem.inst_kill_o = kill;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= SEQ;
            fetch_pc <= RESET_PC;
            pend_tgt <= '0;
            last_acc <= '0;
            acc_any  <= 1'b0;
            resetn_q <= 1'b0;
        end else begin
            resetn_q <= 1'b1;
            if (accept) begin
                last_acc <= fetch_pc;
                acc_any  <= 1'b1;
            end
            if (excp_valid_i) begin
                fetch_pc <= excp_target_i;
                state    <= SEQ;
            end else begin
                unique case (state)
                    SEQ: begin
                        if (br_evt && !ds_done) begin
                            if (ds_now) begin
                                fetch_pc <= br_target_i;
                            end else begin
                                pend_tgt <= br_target_i;
                                state    <= WAIT_DS;
                                if (accept) fetch_pc <= pc_inc;
                            end
                        end else if (br_evt) begin
                            if (accept || !req) begin
                                fetch_pc <= br_target_i;
                            end else begin
                                pend_tgt <= br_target_i;
                                state    <= REDIR;
                            end
                        end else if (accept) begin
                            fetch_pc <= pc_inc;
                        end
                    end
                    WAIT_DS: begin
                        if (accept) begin
                            fetch_pc <= pend_tgt;
                            state    <= SEQ;
                        end
                    end
                    REDIR: begin
                        // Held wrong-path address: leave on accept or idle cycle.
                        if (accept || !req) begin
                            fetch_pc <= pend_tgt;
                            state    <= SEQ;
                        end
                    end
                    default: state <= SEQ;
                endcase
            end
        end
    end

`ifdef IF_REDIRECT_STATS_EN
    logic load_tgt;

    always_comb begin
        load_tgt = 1'b0;
        if (!excp_valid_i) begin
            unique case (state)
                SEQ:     load_tgt = br_evt &
                                    (ds_done ? (accept | ~req) : ds_now);
                WAIT_DS: load_tgt = accept;
                REDIR:   load_tgt = accept | ~req;
                default: load_tgt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            redirect_cnt_o <= '0;
            kill_cnt_o     <= '0;
        end else begin
            if (load_tgt && redirect_cnt_o != '1)
                redirect_cnt_o <= redirect_cnt_o + 1'b1;
            if (kill && kill_cnt_o != '1)
                kill_cnt_o <= kill_cnt_o + 1'b1;
        end
    end
`endif
endmodule
